// File: rtl/param_mem_slave.sv
// Parameterised memory-mapped slave with a fixed response latency and a
// fixed burst length. Requests are taken only on a rising edge of read or
// write. Protocol violations lock the block in an error state until reset.
module param_mem_slave #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned BURST_LEN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] byte_enable,
  output logic [DATA_W-1:0]   rdata,
  output logic                resp,
  output logic                error
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned SHIFT = $clog2(BE_W);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic                read_prev_q, read_prev_d;
  logic                write_prev_q, write_prev_d;
  logic                is_write_q, is_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          lat_q, lat_d;
  logic [3:0]          beat_q, beat_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   word_full;
  logic                in_range;
  logic                read_rise;
  logic                write_rise;
  logic                viol;
  logic                mem_we;
  logic                rd_beat;
  logic [IDX_W-1:0]    idx_next;

  // Request decode: edge detection, word index, range check, violations.
  always_comb begin
    word_full  = addr >> SHIFT;
    in_range   = (word_full < ADDR_W'(DEPTH));
    read_rise  = read & ~read_prev_q;
    write_rise = write & ~write_prev_q;
    idx_next   = (idx_q == IDX_W'(DEPTH - 1)) ? '0 : idx_q + IDX_W'(1);
    viol       = (is_write_q ? ~write : ~read)
               | (is_write_q ? read : write)
               | (addr != addr_q)
               | ((state_q == S_WAIT) && is_write_q && (wdata != wdata_q));
    // A violating beat is not committed; earlier beats stay written.
    mem_we     = (state_q == S_BEAT) && is_write_q && !viol;
    rd_beat    = (state_q == S_BEAT) && !is_write_q;
  end

  // Next-state logic and per-transaction bookkeeping.
  always_comb begin
    state_d      = state_q;
    read_prev_d  = read;
    write_prev_d = write;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lat_d        = lat_q;
    beat_d       = beat_q;
    idx_d        = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (read_rise && write_rise) begin
          state_d = S_ERR;
        end else if (read_rise || write_rise) begin
          if (!in_range) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_WAIT;
            is_write_d = write_rise;
            addr_d     = addr;
            wdata_d    = wdata;
            lat_d      = 8'(LATENCY - 1);
            beat_d     = '0;
            idx_d      = word_full[IDX_W-1:0];
          end
        end
      end
      S_WAIT: begin
        if (viol) begin
          state_d = S_ERR;
        end else if (lat_q == 8'd0) begin
          state_d = S_BEAT;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      S_BEAT: begin
        if (viol) begin
          state_d = S_ERR;
        end else if (beat_q == 4'(BURST_LEN - 1)) begin
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + 4'd1;
          idx_d  = idx_next;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Read data: live memory word during a read beat, otherwise held value.
  always_comb begin
    rdata_d = rd_beat ? mem[idx_q] : rdata_q;
  end

  assign rdata = rdata_d;
  assign resp  = (state_q == S_BEAT);
  assign error = (state_q == S_ERR);

  // Control and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      read_prev_q  <= 1'b0;
      write_prev_q <= 1'b0;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lat_q        <= '0;
      beat_q       <= '0;
      idx_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      read_prev_q  <= read_prev_d;
      write_prev_q <= write_prev_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lat_q        <= lat_d;
      beat_q       <= beat_d;
      idx_q        <= idx_d;
      rdata_q      <= rdata_d;
    end
  end

  // Storage: byte-masked writes, never cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (byte_enable[b]) begin
          mem[idx_q][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_param_mem_slave.sv
// Directed bench for param_mem_slave: one default-parameter instance and one
// wide burst instance (DATA_W=64, DEPTH=4, LATENCY=2, BURST_LEN=4).
module tb_param_mem_slave;

  logic clk;
  int   nvec;
  int   nerr;

  // Instance A: default parameters
  logic        a_rst_n, a_read, a_write, a_resp, a_error;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;

  // Instance B: wide burst configuration
  logic        b_rst_n, b_read, b_write, b_resp, b_error;
  logic [31:0] b_addr;
  logic [63:0] b_wdata, b_rdata;
  logic [7:0]  b_be;

  param_mem_slave #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(4), .BURST_LEN(1)
  ) u_a (
    .clk(clk), .rst_n(a_rst_n), .read(a_read), .write(a_write),
    .addr(a_addr), .wdata(a_wdata), .byte_enable(a_be),
    .rdata(a_rdata), .resp(a_resp), .error(a_error)
  );

  param_mem_slave #(
    .DATA_W(64), .ADDR_W(32), .DEPTH(4), .LATENCY(2), .BURST_LEN(4)
  ) u_b (
    .clk(clk), .rst_n(b_rst_n), .read(b_read), .write(b_write),
    .addr(b_addr), .wdata(b_wdata), .byte_enable(b_be),
    .rdata(b_rdata), .resp(b_resp), .error(b_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-beat transaction on A; checks latency 4, optional read data, and
  // that no further resp appears while the request is held for 'hold' cycles.
  task automatic a_txn(input bit wr, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [3:0] be, input bit chk, input logic [31:0] exp,
                       input int hold, input string tag);
    int lat;
    int extra;
    a_addr  = ad;
    a_wdata = wd;
    a_be    = be;
    if (wr) a_write = 1'b1; else a_read = 1'b1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (a_resp === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, ".latency"}, 64'(lat), 64'd4);
    if (chk) check({tag, ".rdata"}, 64'(a_rdata), 64'(exp));
    extra = 0;
    for (int i = 0; i < 1 + hold; i++) begin
      cyc();
      if (a_resp !== 1'b0) extra++;
    end
    check({tag, ".extra_resp"}, 64'(extra), 64'd0);
    a_read  = 1'b0;
    a_write = 1'b0;
    cyc();
  endtask

  // Reset A, checking that outputs clear before any clock edge.
  task automatic a_reset(input string tag);
    a_read  = 1'b0;
    a_write = 1'b0;
    a_rst_n = 1'b0;
    #1;
    check({tag, ".rst_error"}, 64'(a_error), 64'd0);
    check({tag, ".rst_resp"},  64'(a_resp),  64'd0);
    check({tag, ".rst_rdata"}, 64'(a_rdata), 64'd0);
    cyc();
    cyc();
    a_rst_n = 1'b1;
    cyc();
  endtask

  // Four-beat transaction on B; d0..d3 are per-beat write data or expected read data.
  task automatic b_burst(input bit wr, input logic [31:0] ad,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [63:0] d3,
                         input string tag);
    logic [63:0] d [4];
    int lat;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    b_addr = ad;
    b_be   = '1;
    if (wr) begin
      b_wdata = d[0];
      b_write = 1'b1;
    end else begin
      b_read = 1'b1;
    end
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (b_resp === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, ".latency"}, 64'(lat), 64'd2);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.resp%0d", tag, k), 64'(b_resp), 64'd1);
      if (!wr) check($sformatf("%s.rdata%0d", tag, k), b_rdata, d[k]);
      cyc();
      if (wr && k < 3) b_wdata = d[k+1];
    end
    check({tag, ".done_resp"}, 64'(b_resp), 64'd0);
    b_read  = 1'b0;
    b_write = 1'b0;
    cyc();
  endtask

  initial begin
    int cnt;
    nvec = 0;
    nerr = 0;
    a_rst_n = 1'b0; a_read = 1'b0; a_write = 1'b0;
    a_addr = '0; a_wdata = '0; a_be = '0;
    b_rst_n = 1'b0; b_read = 1'b0; b_write = 1'b0;
    b_addr = '0; b_wdata = '0; b_be = '0;

    cyc();
    cyc();
    check("reset.a_resp",  64'(a_resp),  64'd0);
    check("reset.a_error", 64'(a_error), 64'd0);
    check("reset.a_rdata", 64'(a_rdata), 64'd0);
    check("reset.b_resp",  64'(b_resp),  64'd0);
    check("reset.b_error", 64'(b_error), 64'd0);
    check("reset.b_rdata", b_rdata,      64'd0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    cyc();

    // Basic write then read at 0x10
    a_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 0, "w10");
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 0, "r10");
    check("r10.hold", 64'(a_rdata), 64'hDEAD_BEEF);

    // Byte-enable merge at 0x20
    a_txn(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 0, "w20a");
    a_txn(1'b1, 32'h20, 32'h0000_0000, 4'h5, 1'b0, 32'h0, 0, "w20b");
    a_txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'hFF00_FF00, 0, "r20");

    // Request held after DONE gives no second resp; fresh edge restarts
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 8, "hold");
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 0, "rerise");

    // Last valid word
    a_txn(1'b1, 32'h3FC, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0, 0, "wlast");
    a_txn(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b1, 32'hA5A5_0001, 0, "rlast");

    // First out-of-range word index
    a_addr = 32'h400;
    a_read = 1'b1;
    cyc();
    check("oor.error", 64'(a_error), 64'd1);
    check("oor.resp",  64'(a_resp),  64'd0);
    a_reset("oor");

    // Address change during WAIT of a read
    a_addr = 32'h10;
    a_read = 1'b1;
    cyc();
    cyc();
    check("addrchg.pre_error", 64'(a_error), 64'd0);
    a_addr = 32'h14;
    cyc();
    check("addrchg.error", 64'(a_error), 64'd1);
    a_read = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin
        a_addr  = 32'h10;
        a_wdata = 32'h0;
        a_be    = 4'hF;
        a_write = 1'b1;
      end
      cyc();
      if (a_resp !== 1'b0) cnt++;
    end
    check("addrchg.no_resp",    64'(cnt),     64'd0);
    check("addrchg.err_sticky", 64'(a_error), 64'd1);
    a_reset("addrchg");
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 0, "addrchg_mem");

    // wdata change during WAIT of a write
    a_addr  = 32'h20;
    a_wdata = 32'h1;
    a_be    = 4'hF;
    a_write = 1'b1;
    cyc();
    cyc();
    a_wdata = 32'h2;
    cyc();
    check("wdchg.error", 64'(a_error), 64'd1);
    a_reset("wdchg");
    a_txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'hFF00_FF00, 0, "wdchg_mem");

    // Simultaneous rising read and write
    a_addr  = 32'h10;
    a_read  = 1'b1;
    a_write = 1'b1;
    cyc();
    check("both.error", 64'(a_error), 64'd1);
    check("both.resp",  64'(a_resp),  64'd0);
    a_reset("both");

    // Reset pulse during WAIT of a write leaves the target word intact
    a_addr  = 32'h10;
    a_wdata = 32'h1234_5678;
    a_be    = 4'hF;
    a_write = 1'b1;
    cyc();
    cyc();
    a_reset("midwait");
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 0, "midwait_mem");

    // Wide burst instance
    b_burst(1'b1, 32'h0,  64'd1, 64'd2, 64'd3, 64'd4, "bw0");
    b_burst(1'b0, 32'h0,  64'd1, 64'd2, 64'd3, 64'd4, "br0");
    b_burst(1'b0, 32'h18, 64'd4, 64'd1, 64'd2, 64'd3, "br18");
    b_burst(1'b1, 32'h10, 64'd5, 64'd6, 64'd7, 64'd8, "bw10");
    b_burst(1'b0, 32'h0,  64'd7, 64'd8, 64'd5, 64'd6, "br0b");

    // Word index equal to DEPTH is out of range
    b_addr = 32'h20;
    b_read = 1'b1;
    cyc();
    check("b_oor.error", 64'(b_error), 64'd1);
    check("b_oor.resp",  64'(b_resp),  64'd0);
    b_read  = 1'b0;
    b_rst_n = 1'b0;
    #1;
    check("b_oor.rst_error", 64'(b_error), 64'd0);
    cyc();
    b_rst_n = 1'b1;
    cyc();
    b_burst(1'b0, 32'h8, 64'd8, 64'd5, 64'd6, 64'd7, "br8");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
